// File: rtl/wb_openram_responder.sv
`default_nettype none
// ============================================================================
// Module   : wb_openram_responder
// Purpose  : Wishbone responder for the wrappers' 10-bit shared-RAM bus.
//            Each bus request becomes a single-edge access on one port of a
//            sky130 OpenRAM 1RW macro (256 x 32-bit by default). Only one
//            transaction is in flight at a time. The acknowledge lasts one
//            cycle and the read data is registered.
// Ports    : wb_clk_i / wb_rst_i       clock, synchronous active-high reset
//            wbs_*_i                   Wishbone request (stb, cyc, we, sel,
//                                      dat, adr)
//            wbs_ack_o / wbs_dat_o     acknowledge and registered read data
//            ram_*0_o                  macro port controls (csb/web active low)
//            ram_dout0_i               macro read data, valid one clock after
//                                      the read edge
//            busy_o                    high while a transaction is in progress
// Revision : 1.0 - initial release
// ============================================================================
module wb_openram_responder #(
    parameter int RAM_ADDR_W = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [9:0]            wbs_adr_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  ram_csb0_o,
    output logic                  ram_web0_o,
    output logic [3:0]            ram_wmask0_o,
    output logic [RAM_ADDR_W-1:0] ram_addr0_o,
    output logic [31:0]           ram_din0_o,
    input  logic [31:0]           ram_dout0_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_READ   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ack,   w_ack_nxt;
    logic [31:0]           r_dat,   w_dat_nxt;
    logic                  r_csb,   w_csb_nxt;
    logic                  r_web,   w_web_nxt;
    logic [3:0]            r_wmask, w_wmask_nxt;
    logic [RAM_ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [31:0]           r_din,   w_din_nxt;

    // Byte-offset bits of the address are intentionally ignored.
    logic w_unused_adr;
    assign w_unused_adr = ^wbs_adr_i[1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_dat_nxt   = r_dat;
        w_csb_nxt   = r_csb;
        w_web_nxt   = r_web;
        w_wmask_nxt = r_wmask;
        w_addr_nxt  = r_addr;
        w_din_nxt   = r_din;

        case (r_state)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    w_csb_nxt   = 1'b0;
                    w_web_nxt   = !wbs_we_i;
                    w_addr_nxt  = wbs_adr_i[RAM_ADDR_W+1:2];
                    w_wmask_nxt = wbs_we_i ? wbs_sel_i : 4'b0000;
                    w_din_nxt   = wbs_dat_i;
                    w_state_nxt = S_ACCESS;
                end
            end

            S_ACCESS: begin
                // The macro samples at the edge that ends this state, so the
                // select is dropped here whether or not the cycle survives.
                // r_web still holds the direction of the current access.
                w_csb_nxt = 1'b1;
                w_web_nxt = 1'b1;
                if (!wbs_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (!r_web) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = S_ACK;
                end else begin
                    w_state_nxt = S_READ;
                end
            end

            S_READ: begin
                if (!wbs_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_dat_nxt   = ram_dout0_i;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end

            S_ACK: begin
                w_ack_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_dat   <= 32'd0;
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= 4'b0000;
            r_addr  <= '0;
            r_din   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_dat   <= w_dat_nxt;
            r_csb   <= w_csb_nxt;
            r_web   <= w_web_nxt;
            r_wmask <= w_wmask_nxt;
            r_addr  <= w_addr_nxt;
            r_din   <= w_din_nxt;
        end
    end

    assign wbs_ack_o    = r_ack;
    assign wbs_dat_o    = r_dat;
    assign ram_csb0_o   = r_csb;
    assign ram_web0_o   = r_web;
    assign ram_wmask0_o = r_wmask;
    assign ram_addr0_o  = r_addr;
    assign ram_din0_o   = r_din;
    assign busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire
